// File: rtl/updown_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_pkg
// Brief    : Shared state encoding and default widths for the triangle sweep.
// Revision : 1.0 - initial release
// ============================================================================
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

  localparam int c_W_DEFAULT     = 8;
  localparam int c_CYC_W_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/updown_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : updown_sweep_ctrl_if
// Brief    : Host-side start/busy/done handshake and sweep bounds bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface updown_sweep_ctrl_if
  import updown_pkg::*;
#(
  parameter int W     = c_W_DEFAULT,
  parameter int CYC_W = c_CYC_W_DEFAULT
);

  logic             start;
  logic             abort;
  logic [W-1:0]     lo;
  logic [W-1:0]     hi;
  logic [CYC_W-1:0] cycles;
  logic [W-1:0]     count;
  logic             dir;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, abort, lo, hi, cycles,
    input  count, dir, busy, done, err
  );

  modport slave (
    input  start, abort, lo, hi, cycles,
    output count, dir, busy, done, err
  );

endinterface
`default_nettype wire

// File: rtl/updown_counter_en.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_en
// Brief    : W-bit up/down counter with enable; load takes priority over en.
// Revision : 1.0 - initial release
// ============================================================================
module updown_counter_en
  import updown_pkg::*;
#(
  parameter int W = c_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      if (up) begin
        count <= count + 1'b1;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : updown_sweep_ctrl
// Brief    : Triangle-sweep sequencer lo->hi->lo for a programmed period count.
// Revision : 1.0 - initial release
// ============================================================================
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int W     = c_W_DEFAULT,
  parameter int CYC_W = c_CYC_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  updown_sweep_ctrl_if.slave   bus
);

  sweep_state_t     r_state;
  sweep_state_t     w_next;
  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_hi;
  logic [CYC_W-1:0] r_cycles;
  logic [CYC_W-1:0] r_period;
  logic [CYC_W-1:0] w_period_inc;
  logic             r_done;
  logic             r_err;

  logic             w_en;
  logic             w_up;
  logic             w_load;
  logic             w_latch;
  logic             w_period_step;
  logic             w_err_req;
  logic [W-1:0]     w_count;

  updown_counter_en #(
    .W (W)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_en),
    .up       (w_up),
    .load     (w_load),
    .load_val (bus.lo),
    .count    (w_count)
  );

  // Saturates so continuous mode can never wrap back to a matching value.
  assign w_period_inc = (r_period == '1) ? r_period : r_period + 1'b1;

  always_comb begin
    w_next        = r_state;
    w_en          = 1'b0;
    w_up          = 1'b1;
    w_load        = 1'b0;
    w_latch       = 1'b0;
    w_period_step = 1'b0;
    w_err_req     = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (bus.lo < bus.hi) begin
            w_load  = 1'b1;
            w_latch = 1'b1;
            w_next  = UP;
          end else begin
            w_err_req = 1'b1;
          end
        end
      end

      UP: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (w_count < r_hi) begin
          w_en = 1'b1;
        end else begin
          w_en   = 1'b1;
          w_up   = 1'b0;
          w_next = DOWN;
        end
      end

      DOWN: begin
        if (bus.abort) begin
          w_next = IDLE;
        end else if (w_count > r_lo) begin
          w_en = 1'b1;
          w_up = 1'b0;
        end else begin
          // Bottom of a period: the shared lo ends this one and starts the next.
          w_period_step = 1'b1;
          if ((r_cycles != '0) && (w_period_inc == r_cycles)) begin
            w_next = DONE;
          end else begin
            w_en   = 1'b1;
            w_next = UP;
          end
        end
      end

      DONE: begin
        w_next = IDLE;
      end

      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_cycles <= '0;
      r_period <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_lo     <= bus.lo;
        r_hi     <= bus.hi;
        r_cycles <= bus.cycles;
        r_period <= '0;
      end else if (w_period_step) begin
        r_period <= w_period_inc;
      end
      r_done <= (r_state == DOWN) && (w_next == DONE);
      r_err  <= w_err_req;
    end
  end

  assign bus.count = w_count;
  assign bus.dir   = (r_state != DOWN);
  assign bus.busy  = (r_state == UP) || (r_state == DOWN);
  assign bus.done  = r_done;
  assign bus.err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_sweep_ctrl
// Brief    : Directed self-checking bench for the triangle-sweep sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_sweep_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  updown_sweep_ctrl_if #(.W(8), .CYC_W(4)) bus ();

  updown_sweep_ctrl #(
    .W     (8),
    .CYC_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle start; returns just after the edge that samples it.
  task automatic start_sweep(input logic [7:0] l, input logic [7:0] h, input logic [3:0] c);
    bus.lo     = l;
    bus.hi     = h;
    bus.cycles = c;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp2_cnt [5] = '{2, 3, 4, 3, 2};
    int exp2_dir [5] = '{1, 1, 1, 0, 0};
    int exp6_cnt [5] = '{1, 2, 3, 2, 1};
    int exp7_cnt [5] = '{254, 255, 254, 255, 254};
    int exp7_dir [5] = '{1, 1, 0, 1, 0};
    int done_seen;

    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.lo     = '0;
    bus.hi     = '0;
    bus.cycles = '0;
    rst_n      = 1'b0;
    step();
    step();
    check("rst_count", bus.count, 0);
    check("rst_busy",  bus.busy,  0);
    check("rst_dir",   bus.dir,   1);
    check("rst_done",  bus.done,  0);
    check("rst_err",   bus.err,   0);
    rst_n = 1'b1;
    step();

    // lo=2 hi=4 one period: done lands 2*2*1+1 = 5 edges after the start edge
    start_sweep(8'd2, 8'd4, 4'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      check($sformatf("t2_count_k%0d", k), bus.count, exp2_cnt[k]);
      check($sformatf("t2_dir_k%0d", k),   bus.dir,   exp2_dir[k]);
      check($sformatf("t2_busy_k%0d", k),  bus.busy,  1);
    end
    step();
    check("t2_done",       bus.done,  1);
    check("t2_done_count", bus.count, 2);
    check("t2_done_busy",  bus.busy,  0);
    step();
    check("t2_done_pulse", bus.done,  0);
    check("t2_idle_count", bus.count, 2);

    // Full-range sweep, two periods: done 2*255*2+1 = 1021 edges after start
    start_sweep(8'd0, 8'd255, 4'd2);
    check("t3_first", bus.count, 0);
    done_seen = 0;
    for (int k = 1; k <= 1021; k++) begin
      step();
      if (bus.done) done_seen++;
      case (k)
        255: begin
          check("t3_top_count", bus.count, 255);
          check("t3_top_dir",   bus.dir,   1);
        end
        256: begin
          check("t3_turn_count", bus.count, 254);
          check("t3_turn_dir",   bus.dir,   0);
        end
        510: begin
          check("t3_mid_count", bus.count, 0);
          check("t3_mid_dir",   bus.dir,   0);
        end
        511: begin
          check("t3_rise_count", bus.count, 1);
          check("t3_rise_dir",   bus.dir,   1);
          check("t3_rise_busy",  bus.busy,  1);
        end
        765: check("t3_top2_count", bus.count, 255);
        1020: begin
          check("t3_last_count", bus.count, 0);
          check("t3_last_done",  bus.done,  0);
        end
        default: ;
      endcase
    end
    check("t3_done",       bus.done,  1);
    check("t3_done_once",  done_seen, 1);
    check("t3_done_count", bus.count, 0);
    check("t3_done_busy",  bus.busy,  0);
    step();

    // Illegal bounds: err pulse, no sweep
    start_sweep(8'd5, 8'd5, 4'd3);
    check("t4_err",   bus.err,   1);
    check("t4_busy",  bus.busy,  0);
    check("t4_count", bus.count, 0);
    step();
    check("t4_err_pulse", bus.err,  0);
    check("t4_busy2",     bus.busy, 0);
    start_sweep(8'd9, 8'd4, 4'd1);
    check("t4_err_inv",  bus.err,  1);
    check("t4_busy_inv", bus.busy, 0);
    step();

    // Continuous: 121 edges spans period-counter saturation; abort at 11
    start_sweep(8'd10, 8'd12, 4'd0);
    done_seen = 0;
    for (int k = 1; k <= 121; k++) begin
      step();
      if (bus.done) done_seen++;
      if (k == 120) check("t5_k120_count", bus.count, 10);
    end
    check("t5_no_done",  done_seen, 0);
    check("t5_pre_cnt",  bus.count, 11);
    check("t5_pre_busy", bus.busy,  1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("t5_abort_busy",  bus.busy,  0);
    check("t5_abort_count", bus.count, 11);
    check("t5_abort_dir",   bus.dir,   1);
    check("t5_abort_done",  bus.done,  0);
    check("t5_abort_err",   bus.err,   0);
    step();
    check("t5_idle_count", bus.count, 11);
    check("t5_idle_done",  bus.done,  0);

    // start together with abort in IDLE is dropped
    bus.lo     = 8'd1;
    bus.hi     = 8'd3;
    bus.cycles = 4'd1;
    bus.start  = 1'b1;
    bus.abort  = 1'b1;
    step();
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    check("t6_sa_busy",  bus.busy,  0);
    check("t6_sa_count", bus.count, 11);
    check("t6_sa_err",   bus.err,   0);

    // Restart while busy and live bound changes must not disturb the sweep
    start_sweep(8'd1, 8'd3, 4'd1);
    check("t6_count_k0", bus.count, exp6_cnt[0]);
    bus.lo     = 8'd0;
    bus.hi     = 8'd200;
    bus.cycles = 4'd5;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    check("t6_count_k1", bus.count, exp6_cnt[1]);
    for (int k = 2; k < 5; k++) begin
      step();
      check($sformatf("t6_count_k%0d", k), bus.count, exp6_cnt[k]);
    end
    step();
    check("t6_done",       bus.done,  1);
    check("t6_done_count", bus.count, 1);
    step();

    // hi-lo==1 at the top bound: alternates, two periods, no wrap past 255
    start_sweep(8'd254, 8'd255, 4'd2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      check($sformatf("t7_count_k%0d", k), bus.count, exp7_cnt[k]);
      check($sformatf("t7_dir_k%0d", k),   bus.dir,   exp7_dir[k]);
    end
    step();
    check("t7_done",       bus.done,  1);
    check("t7_done_count", bus.count, 254);
    step();

    // Asynchronous reset mid-sweep takes effect without a clock edge
    start_sweep(8'd3, 8'd9, 4'd0);
    step();
    step();
    step();
    check("t1_pre_count", bus.count, 6);
    rst_n = 1'b0;
    #1;
    check("t1_rst_count", bus.count, 0);
    check("t1_rst_busy",  bus.busy,  0);
    check("t1_rst_dir",   bus.dir,   1);
    step();
    rst_n = 1'b1;
    step();
    check("t1_post_count", bus.count, 0);
    check("t1_post_busy",  bus.busy,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
